// File: rtl/serial_sub8.sv
// Bit-serial 8-bit subtractor: diff = a - b - bin, one bit per cycle, LSB first.
// Define SUB8_OVF_EN to add the registered signed-overflow output ovf.
module serial_sub8 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
`ifdef SUB8_OVF_EN
  output logic             bout,
  output logic             ovf
`else
  output logic             bout
`endif
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state, state_nx;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_q, b_q, sh, sh_nx;
  logic             br, br_nx, d, a_i, b_i, last;

  // Operands stay parallel and are indexed by the counter, so the MSBs
  // remain available for the overflow term at the final bit.
  always_comb begin
    a_i   = a_q[cnt];
    b_i   = b_q[cnt];
    d     = a_i ^ b_i ^ br;
    br_nx = (~a_i & b_i) | (~a_i & br) | (b_i & br);
    sh_nx = {d, sh[WIDTH-1:1]};
    last  = (cnt == CW'(WIDTH - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = BUSY;
      BUSY:    if (last)  state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
    done = (state == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q  <= '0;
      b_q  <= '0;
      br   <= 1'b0;
      cnt  <= '0;
      sh   <= '0;
      diff <= '0;
      bout <= 1'b0;
`ifdef SUB8_OVF_EN
      ovf  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_q <= a;
            b_q <= b;
            br  <= bin;
            cnt <= '0;
          end
        end
        BUSY: begin
          br  <= br_nx;
          sh  <= sh_nx;
          cnt <= cnt + CW'(1);
          if (last) begin
            diff <= sh_nx;
            bout <= br_nx;
`ifdef SUB8_OVF_EN
            ovf  <= (a_q[WIDTH-1] ^ b_q[WIDTH-1]) & (d ^ a_q[WIDTH-1]);
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_sub8.sv
// Self-checking bench for serial_sub8: directed table, corner sequences and
// randomized operations against an arithmetic reference model.
module tb_serial_sub8;

  logic       clk, rst_n, start, bin;
  logic [7:0] a, b, diff;
  logic       busy, done, bout;
`ifdef SUB8_OVF_EN
  logic       ovf;
`endif

  int checks = 0;
  int errors = 0;
  logic [7:0] prev_diff = '0;
  logic       prev_bout = 1'b0;

  serial_sub8 #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
`ifdef SUB8_OVF_EN
    .bout  (bout),
    .ovf   (ovf)
`else
    .bout  (bout)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       bin;
    logic [7:0] d;
    logic       bo;
    logic       ov;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic void model(input logic [7:0] ta, input logic [7:0] tb, input logic tbin,
                                output logic [7:0] d, output logic bo, output logic ov);
    int r;
    r  = int'(ta) - int'(tb) - int'(tbin);
    d  = r[7:0];
    bo = (r < 0);
    ov = (ta[7] != tb[7]) && (d[7] != ta[7]);
  endfunction

  task automatic launch(input logic [7:0] ta, input logic [7:0] tb, input logic tbin);
    @(negedge clk);
    a = ta; b = tb; bin = tbin; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("accept_busy", busy, 1);
  endtask

  // Waits for completion after launch; optional noise on inputs while busy.
  task automatic finish_op(input string name, input logic [7:0] ta, input logic [7:0] tb,
                           input logic tbin, input logic [7:0] ed, input logic eb,
                           input logic eo, input bit noise);
    int lat;
    bit got, busy_ok, stable_ok;
    lat = 0; got = 0; busy_ok = 1; stable_ok = 1;
    while (lat < 20 && !got) begin
      @(posedge clk); #1;
      lat++;
      if (done) got = 1;
      else begin
        if (!busy) busy_ok = 0;
        if (diff !== prev_diff || bout !== prev_bout) stable_ok = 0;
        if (noise) begin
          a = 8'($urandom); b = 8'($urandom); bin = 1'($urandom); start = 1'($urandom);
        end
      end
    end
    start = 1'b0;
    chk({name, "_done_seen"}, got, 1);
    chk({name, "_latency"}, lat, 8);
    chk({name, "_diff"}, diff, ed);
    chk({name, "_bout"}, bout, eb);
`ifdef SUB8_OVF_EN
    chk({name, "_ovf"}, ovf, eo);
`endif
    chk({name, "_busy_held"}, busy_ok, 1);
    chk({name, "_result_stable"}, stable_ok, 1);
    @(posedge clk); #1;
    chk({name, "_done_width"}, done, 0);
    chk({name, "_idle_busy"}, busy, 0);
    prev_diff = ed;
    prev_bout = eb;
  endtask

  initial begin
    logic [7:0] ed;
    logic eb, eo;
    int ndone, first, d1, d2;
    bit busy_ok;

    tbl[0] = '{8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0};
    tbl[1] = '{8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0};
    tbl[2] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0};
    tbl[3] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1};
    tbl[4] = '{8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0, 1'b0};
    tbl[5] = '{8'h00, 8'hFF, 1'b0, 8'h01, 1'b1, 1'b0};
    tbl[6] = '{8'h7F, 8'h80, 1'b0, 8'hFF, 1'b1, 1'b1};
    tbl[7] = '{8'hFF, 8'h00, 1'b1, 8'hFE, 1'b0, 1'b0};

    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; bin = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_diff", diff, 0);
    chk("rst_bout", bout, 0);
`ifdef SUB8_OVF_EN
    chk("rst_ovf", ovf, 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      launch(tbl[i].a, tbl[i].b, tbl[i].bin);
      finish_op($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].bin,
                tbl[i].d, tbl[i].bo, tbl[i].ov, 1'b0);
    end

    // Restart attempt in the middle of BUSY must be ignored.
    launch(8'h10, 8'h01, 1'b0);
    ndone = 0; first = 0; busy_ok = 1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (i == 3) begin start = 1'b1; a = 8'hFF; b = 8'hFF; bin = 1'b1; end
      if (i == 5) start = 1'b0;
      if (done) begin ndone++; if (first == 0) first = i; end
      if (i <= 8 && !busy) busy_ok = 0;
    end
    chk("midbusy_done_count", ndone, 1);
    chk("midbusy_latency", first, 8);
    chk("midbusy_busy_held", busy_ok, 1);
    chk("midbusy_diff", diff, 8'h0F);
    chk("midbusy_bout", bout, 0);

    // Back-to-back: second start raised in the IDLE cycle right after DONE.
    launch(8'h20, 8'h10, 1'b0);
    d1 = 0; d2 = 0;
    for (int i = 1; i <= 30; i++) begin
      @(posedge clk); #1;
      if (d1 != 0 && i == d1 + 2) start = 1'b0;
      if (d1 != 0 && i == d1 + 1) begin
        chk("b2b_idle_gap", busy, 0);
        a = 8'h10; b = 8'h20; bin = 1'b0; start = 1'b1;
      end
      if (done && d1 == 0) begin
        d1 = i;
        chk("b2b_first_diff", diff, 8'h10);
        chk("b2b_first_bout", bout, 0);
      end else if (done && d2 == 0) begin
        d2 = i;
        chk("b2b_second_diff", diff, 8'hF0);
        chk("b2b_second_bout", bout, 1);
      end
    end
    start = 1'b0;
    chk("b2b_first_latency", d1, 8);
    // Accept, 8 BUSY cycles, DONE, IDLE: 9 cycles lie strictly between pulses.
    chk("b2b_pulse_spacing", d2 - d1, 10);

    // Reset during the 4th BUSY cycle: outputs clear at once, no done follows.
    launch(8'h33, 8'h11, 1'b0);
    repeat (3) begin @(posedge clk); #1; end
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_diff", diff, 0);
    chk("midrst_bout", bout, 0);
`ifdef SUB8_OVF_EN
    chk("midrst_ovf", ovf, 0);
`endif
    @(posedge clk); #1;
    chk("midrst_hold_done", done, 0);
    chk("midrst_hold_busy", busy, 0);
    #1 rst_n = 1'b1;
    prev_diff = '0; prev_bout = 1'b0;
    launch(8'h09, 8'h04, 1'b0);
    finish_op("post_rst", 8'h09, 8'h04, 1'b0, 8'h05, 1'b0, 1'b0, 1'b0);

    for (int n = 0; n < 150; n++) begin
      logic [7:0] ra, rb;
      logic rbin;
      ra = 8'($urandom); rb = 8'($urandom); rbin = 1'($urandom);
      if (n % 16 == 0) rbin = 1'b1;
      model(ra, rb, rbin, ed, eb, eo);
      launch(ra, rb, rbin);
      finish_op($sformatf("rand%0d_%02h_%02h_%0d", n, ra, rb, rbin), ra, rb, rbin,
                ed, eb, eo, 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
